// File: rtl/sequenciador_multiciclo.sv
// ============================================================================
// sequenciador_multiciclo : multi-cycle control sequencer with memory-wait
//                           timeout. Optional macro SEQ_INSTR_COUNT_EN adds a
//                           16-bit instruction completion counter output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sequenciador_multiciclo #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] MemInstruc,
   input  logic       mem_ack,
   input  logic       ula_zero,
   input  logic       resume,
   output logic       ir_write,
   output logic       EscPC,
   output logic       pc_src,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       Load,
   output logic       RegWrite,
   output logic       Slt,
   output logic       halted,
   output logic       mem_err,
   output logic [1:0] ULAOp,
   output logic [1:0] ULAsrc1,
   output logic [1:0] ULAsrc2,
   output logic [2:0] state
`ifdef SEQ_INSTR_COUNT_EN
   ,
   output logic [15:0] instr_count
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD, OP_ADDI, OP_LOAD, OP_STORE, OP_SLT,
      OP_BEQ, OP_RESET, OP_OR, OP_SETBOOL, OP_HALT
   } op_t;

   typedef struct packed {
      logic       ir_write;
      logic       esc_pc;
      logic       pc_src;
      logic       mem_read;
      logic       mem_write;
      logic       load;
      logic       reg_write;
      logic       slt;
      logic       halted;
      logic [1:0] ula_op;
      logic [1:0] ula_src1;
      logic [1:0] ula_src2;
   } ctl_t;

   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

   state_t     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] wait_q, wait_d;
   logic       mem_err_q, mem_err_d;
   logic       complete_c;
   op_t        op_c;
   ctl_t       ctl_c, ctl_out;

   always_comb begin
      op_c = OP_ADD;
      case (ir_q[7:5])
         3'b000:  op_c = OP_ADD;
         3'b001:  op_c = OP_ADDI;
         3'b010:  op_c = OP_LOAD;
         3'b011:  op_c = OP_STORE;
         3'b100,
         3'b101:  op_c = OP_SLT;
         3'b111:  op_c = OP_BEQ;
         default: begin
            case (ir_q[1:0])
               2'b00:   op_c = OP_RESET;
               2'b01:   op_c = OP_OR;
               2'b10:   op_c = OP_SETBOOL;
               default: op_c = OP_HALT;
            endcase
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      wait_d     = '0;
      mem_err_d  = mem_err_q;
      complete_c = 1'b0;
      ctl_c      = '0;
      case (state_q)
         S_FETCH: begin
            ctl_c.mem_read = 1'b1;
            if (mem_ack) begin
               ctl_c.ir_write = 1'b1;
               ctl_c.esc_pc   = 1'b1;
               ir_d           = MemInstruc;
               state_d        = S_DECODE;
            end else if (wait_q == WAIT_LAST) begin
               mem_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: begin
            if (op_c == OP_HALT) begin
               state_d    = S_HALT;
               complete_c = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_WB;
            case (op_c)
               OP_ADD:     {ctl_c.ula_op, ctl_c.ula_src1, ctl_c.ula_src2} = 6'b00_10_00;
               OP_ADDI:    {ctl_c.ula_op, ctl_c.ula_src1, ctl_c.ula_src2} = 6'b00_10_10;
               OP_SLT: begin
                  {ctl_c.ula_op, ctl_c.ula_src1, ctl_c.ula_src2} = 6'b01_10_10;
                  ctl_c.slt = 1'b1;
               end
               OP_RESET:   {ctl_c.ula_op, ctl_c.ula_src1, ctl_c.ula_src2} = 6'b00_10_00;
               OP_OR:      {ctl_c.ula_op, ctl_c.ula_src1, ctl_c.ula_src2} = 6'b11_11_01;
               OP_SETBOOL: {ctl_c.ula_op, ctl_c.ula_src1, ctl_c.ula_src2} = 6'b10_11_00;
               OP_BEQ: begin
                  {ctl_c.ula_op, ctl_c.ula_src1, ctl_c.ula_src2} = 6'b11_11_01;
                  ctl_c.esc_pc = ula_zero;
                  ctl_c.pc_src = ula_zero;
                  state_d      = S_FETCH;
                  complete_c   = 1'b1;
               end
               OP_LOAD,
               OP_STORE:   state_d = S_MEM;
               default:    state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (op_c == OP_STORE) begin
               ctl_c.mem_write = 1'b1;
            end else begin
               ctl_c.mem_read = 1'b1;
               ctl_c.load     = 1'b1;
            end
            if (mem_ack) begin
               state_d    = (op_c == OP_STORE) ? S_FETCH : S_WB;
               complete_c = (op_c == OP_STORE);
            end else if (wait_q == WAIT_LAST) begin
               mem_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WB: begin
            ctl_c.reg_write = 1'b1;
            ctl_c.load      = (op_c == OP_LOAD);
            state_d         = S_FETCH;
            complete_c      = 1'b1;
         end
         S_HALT: begin
            ctl_c.halted = 1'b1;
            if (resume) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
      end
   end

   // Strobes are gated by rst_n so they drop the instant reset asserts.
   assign ctl_out  = rst_n ? ctl_c : '0;
   assign ir_write = ctl_out.ir_write;
   assign EscPC    = ctl_out.esc_pc;
   assign pc_src   = ctl_out.pc_src;
   assign MemRead  = ctl_out.mem_read;
   assign MemWrite = ctl_out.mem_write;
   assign Load     = ctl_out.load;
   assign RegWrite = ctl_out.reg_write;
   assign Slt      = ctl_out.slt;
   assign halted   = ctl_out.halted;
   assign ULAOp    = ctl_out.ula_op;
   assign ULAsrc1  = ctl_out.ula_src1;
   assign ULAsrc2  = ctl_out.ula_src2;
   assign mem_err  = mem_err_q;
   assign state    = state_q;

   logic unused_ir_bits;
   assign unused_ir_bits = &{1'b0, ir_q[4:2]};

`ifdef SEQ_INSTR_COUNT_EN
   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q + 16'(complete_c);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign instr_count = count_q;
`else
   logic unused_complete;
   assign unused_complete = complete_c;
`endif

endmodule

`default_nettype wire
